// File: rtl/align_rshift_seq.sv
// Sequential right-shift alignment unit: one binary shift stage per clock,
// logical or arithmetic, producing aligned mantissa plus guard/round/sticky.
module align_rshift_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_guard,
  output logic             out_round,
  output logic             out_sticky
);

  localparam int XW = WIDTH + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

  logic [1:0]     state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic           s_q, s_d;
  logic [SHW-1:0] a_q, a_d;
  logic           f_q, f_d;
  logic [SHW-1:0] k_q, k_d;

  // Stage k shifts X right by 2^k, filling with F, and ORs the dropped bits.
  logic [2*XW-1:0] stage_ext;
  logic [XW-1:0]   stage_x;
  logic            stage_drop;
  int              stage_amt;

  always_comb begin
    stage_amt  = 1 << k_q;
    stage_ext  = {{XW{f_q}}, x_q} >> stage_amt;
    stage_x    = stage_ext[XW-1:0];
    stage_drop = 1'b0;
    for (int i = 0; i < XW; i++) begin
      if (i < stage_amt) stage_drop = stage_drop | x_q[i];
    end
  end

  // NOTE: every next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    s_d     = s_q;
    a_d     = a_q;
    f_d     = f_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = {in_data, 2'b00};
          s_d     = 1'b0;
          a_d     = in_shift;
          f_d     = in_arith & in_data[WIDTH-1];
          k_d     = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (a_q[k_q]) begin
          x_d = stage_x;
          s_d = s_q | stage_drop;
        end
        // Every stage costs a cycle, even when its shift bit is clear.
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and the whole
  // datapath is cleared on reset so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      s_q     <= 1'b0;
      a_q     <= '0;
      f_q     <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      s_q     <= s_d;
      a_q     <= a_d;
      f_q     <= f_d;
      k_q     <= k_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_data   = x_q[XW-1:2];
  assign out_guard  = x_q[1];
  assign out_round  = x_q[0];
  assign out_sticky = s_q;

endmodule

// File: tb/tb_align_rshift_seq.sv
// Directed plus random bench for align_rshift_seq; expected results are
// queued at accept time and compared when the DUT hands off a result.
module tb_align_rshift_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shift;
  logic       in_arith;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_guard;
  logic       out_round;
  logic       out_sticky;

  align_rshift_seq #(.WIDTH(8), .SHW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_guard (out_guard),
    .out_round (out_round),
    .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       g;
    logic       r;
    logic       s;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic g, input logic r, input logic s);
    exp_t e;
    e.d = d; e.g = g; e.r = r; e.s = s; e.acc = 0;
    return e;
  endfunction

  // Reference: one-shot shift of {data,00}, sticky = OR of the sh lowest bits.
  function automatic exp_t model(input logic [7:0] d, input logic [2:0] sh, input logic ar);
    logic [9:0] x;
    logic [9:0] y;
    logic       st;
    x  = {d, 2'b00};
    st = 1'b0;
    for (int i = 0; i < 10; i++) if (i < int'(sh)) st = st | x[i];
    y  = (ar && d[7]) ? 10'($signed(x) >>> sh) : (x >> sh);
    return mk(y[9:2], y[1], y[0], st);
  endfunction

  // Scoreboard side: latency on the rising out_valid, contents on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov && sb.size() != 0)
        check("latency", cyc - sb[0].acc, 3);
      if (out_valid && out_ready) begin
        check("sb_has_entry", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out_data",   out_data,   e.d);
          check("out_guard",  out_guard,  e.g);
          check("out_round",  out_round,  e.r);
          check("out_sticky", out_sticky, e.s);
        end
      end
    end
    prev_ov = out_valid;
  end

  // Entered and left at posedge+1; returns the cycle of the accept edge.
  task automatic send(input logic [7:0] d, input logic [2:0] sh, input logic ar,
                      input exp_t e, output int acc);
    int   budget;
    exp_t ee;
    budget   = 0;
    in_data  = d;
    in_shift = sh;
    in_arith = ar;
    in_valid = 1'b1;
    while (!in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    acc = -1;
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc      = cyc;
      in_valid = 1'b0;
      in_data  = ~d;
      in_shift = ~sh;
      in_arith = ~ar;
      ee       = e;
      ee.acc   = acc;
      sb.push_back(ee);
    end
  endtask

  task automatic wait_ov();
    int budget;
    budget = 0;
    while (!out_valid && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || !in_ready) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int         a1;
    int         a2;
    logic [7:0] hold_d;
    logic       hold_g, hold_r, hold_s;
    logic [7:0] rd;
    logic [2:0] rsh;
    logic       rar;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0;
    in_arith = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready",  in_ready,   1);
    check("rst_out_valid", out_valid,  0);
    check("rst_out_data",  out_data,   0);
    check("rst_grs", {out_guard, out_round, out_sticky}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(8'hB6, 3'd3, 1'b0, mk(8'h16, 1'b1, 1'b1, 1'b0), a1);
    send(8'hFF, 3'd7, 1'b0, mk(8'h01, 1'b1, 1'b1, 1'b1), a1);
    send(8'h80, 3'd2, 1'b1, mk(8'hE0, 1'b0, 1'b0, 1'b0), a1);
    send(8'h80, 3'd2, 1'b0, mk(8'h20, 1'b0, 1'b0, 1'b0), a1);
    send(8'h5A, 3'd0, 1'b0, mk(8'h5A, 1'b0, 1'b0, 1'b0), a1);
    drain();

    // Backpressure: result must hold and a stray in_valid must be ignored.
    out_ready = 1'b0;
    send(8'h3C, 3'd1, 1'b0, model(8'h3C, 3'd1, 1'b0), a1);
    wait_ov();
    hold_d = out_data; hold_g = out_guard; hold_r = out_round; hold_s = out_sticky;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_data  = 8'hFF;
      in_shift = 3'd5;
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready",  in_ready,  0);
      check("bp_stable", {out_data, out_guard, out_round, out_sticky},
            {hold_d, hold_g, hold_r, hold_s});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_in_ready",  in_ready,  1);
    check("post_hs_out_valid", out_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    check("stray_not_accepted", out_valid, 0);

    // Back-to-back: in_ready is low for SHW+1 cycles (3 stages + DONE),
    // so the second accept lands at the edge after the handshake, 5 edges on.
    send(8'hC3, 3'd4, 1'b1, model(8'hC3, 3'd4, 1'b1), a1);
    send(8'h71, 3'd5, 1'b0, model(8'h71, 3'd5, 1'b0), a2);
    check("accept_spacing", a2 - a1, 5);
    drain();

    // Reset in the middle of the shift sequence.
    send(8'hB6, 3'd3, 1'b0, mk(8'h16, 1'b1, 1'b1, 1'b0), a1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready",  in_ready,  1);
    check("abort_out_data",  out_data,  0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'hB6, 3'd3, 1'b0, mk(8'h16, 1'b1, 1'b1, 1'b0), a1);
    drain();

    for (int i = 0; i < 8; i++) begin
      rd  = 8'($urandom);
      rsh = 3'($urandom_range(0, 7));
      rar = 1'($urandom_range(0, 1));
      send(rd, rsh, rar, model(rd, rsh, rar), a1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
